// File: rtl/alu_pkg.sv
// Shared ALU encodings and sequencer state type used by the execute-stage
// multiply/divide sequencer and the ALU input mux.
package alu_pkg;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative 32x32 unsigned multiply / 32/32 unsigned divide that borrows the
// shared ALU: ADD for shift-add multiply, SUB for restoring division.
module alu_muldiv_seq
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic        dz,
  output logic [31:0] result_lo,
  output logic [31:0] result_hi,
  output logic [1:0]  alu_ctrl,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_result,
  input  logic [3:0]  alu_flags
);

  state_t      state, state_next;
  logic [31:0] hi, lo, opnd;
  logic [4:0]  cnt;
  logic        op_r;
  logic [31:0] hi_next, lo_next;
  logic        carry, ok;
  logic        accept, div_zero;
  logic        last_iter;
  logic        unused_flags;

  assign unused_flags = ^{alu_flags[FLAG_N], alu_flags[FLAG_Z], alu_flags[FLAG_V]};

  assign accept    = (state == IDLE) && start;
  assign div_zero  = (op == OP_DIV) && (b == 32'd0);
  assign last_iter = (state == RUN) && (cnt == 5'd31);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = div_zero ? DONE : RUN;
      RUN:     if (cnt == 5'd31) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ALU operands are only driven while iterating; idle/done present zeros.
  always_comb begin
    busy     = (state != IDLE);
    done     = (state == DONE);
    alu_ctrl = ALU_ADD;
    alu_a    = 32'd0;
    alu_b    = 32'd0;
    if (state == RUN) begin
      if (op_r == OP_MUL) begin
        alu_ctrl = ALU_ADD;
        alu_a    = hi;
        alu_b    = lo[0] ? opnd : 32'd0;
      end else begin
        alu_ctrl = ALU_SUB;
        alu_a    = {hi[30:0], lo[31]};
        alu_b    = opnd;
      end
    end
  end

  // hi[31] set means the shifted partial remainder is 33 bits wide, so it
  // always exceeds the divisor even though the ALU borrow says otherwise.
  always_comb begin
    carry = alu_flags[FLAG_C];
    ok    = carry | hi[31];
    if (op_r == OP_MUL) begin
      {hi_next, lo_next} = {carry, alu_result, lo[31:1]};
    end else begin
      hi_next = ok ? alu_result : alu_a;
      lo_next = {lo[30:0], ok};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi        <= 32'd0;
      lo        <= 32'd0;
      opnd      <= 32'd0;
      cnt       <= 5'd0;
      op_r      <= OP_MUL;
      dz        <= 1'b0;
      result_lo <= 32'd0;
      result_hi <= 32'd0;
    end else if (accept) begin
      hi   <= 32'd0;
      lo   <= (op == OP_MUL) ? b : a;
      opnd <= (op == OP_MUL) ? a : b;
      cnt  <= 5'd0;
      op_r <= op;
      dz   <= div_zero;
      if (div_zero) begin
        result_lo <= 32'hFFFF_FFFF;
        result_hi <= a;
      end
    end else if (state == RUN) begin
      hi  <= hi_next;
      lo  <= lo_next;
      cnt <= cnt + 5'd1;
      if (last_iter) begin
        result_lo <= lo_next;
        result_hi <= hi_next;
      end
    end
  end

endmodule
